// File: rtl/press_seq_ctrl_if.sv
// Button-side / counter-side signal bundle for press_seq_ctrl.
// master: drives the raw button level and observes counter controls and events.
// slave : samples the button and drives count_en, count_clr, state, press_evt, long_evt.
interface press_seq_ctrl_if;
    logic       press;      // raw button level, asynchronous, may bounce
    logic       count_en;   // counter enable, high only in RUN
    logic       count_clr;  // one-cycle counter clear pulse
    logic [1:0] state;      // 00 IDLE, 01 RUN, 10 HOLD
    logic       press_evt;  // one-cycle pulse per accepted short press
    logic       long_evt;   // one-cycle pulse per accepted long press

    modport master (output press, input count_en, count_clr, state, press_evt, long_evt);
    modport slave  (input press, output count_en, count_clr, state, press_evt, long_evt);
endinterface

// File: rtl/press_seq_ctrl.sv
// Push-button sequencer: synchronise, debounce, classify short/long presses, drive counter enable/clear.
// Latency: raw edge -> debounced edge SYNC_STAGES+DEBOUNCE_CYC cycles; events and FSM outputs registered on that edge.
// Backpressure: none; the counter must accept count_en/count_clr every cycle.
// Ports: clk, rst (async active-low), bus (slave modport: press in; count_en, count_clr, state, press_evt, long_evt out).
module press_seq_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int LONG_CYC     = 16
) (
    input  logic             clk,
    input  logic             rst,
    press_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_ILL  = 2'b11
    } state_t;

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   db_q, db_d;
    logic [DW-1:0]          deb_q, deb_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   short_w, long_w;

    // Kept as a raw vector rather than state_t so an upset into the unused
    // code 11 is representable and recovered from.
    logic [1:0]             state_q;
    state_t                 state_d;
    logic                   clr_d;

    logic                   count_en_q, count_clr_q, press_evt_q, long_evt_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // Input conditioning and press classification.
    always_comb begin
        db_d   = db_q;
        deb_d  = '0;
        if (synced != db_q) begin
            // The DEBOUNCE_CYC-th consecutive differing cycle flips the level.
            if (deb_q == DEB_LAST) begin
                db_d = ~db_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end

        hold_d = '0;
        if (db_q) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end

        // Hold timer saturates at LONG_CYC, so long fires exactly once per press.
        long_w  = db_q && (hold_q == HOLD_LAST);
        // A release on the same edge long fires, or after it, is not a short press.
        short_w = db_q && !db_d && (hold_q < HOLD_LAST);
    end

    always_comb begin
        state_d = ST_IDLE;
        clr_d   = 1'b0;
        case (state_t'(state_q))
            ST_IDLE: begin
                state_d = ST_IDLE;
                if (short_w)     state_d = ST_RUN;
                else if (long_w) clr_d   = 1'b1;
            end
            ST_RUN: begin
                state_d = ST_RUN;
                if (short_w) begin
                    state_d = ST_HOLD;
                end else if (long_w) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d = ST_HOLD;
                if (short_w) begin
                    state_d = ST_RUN;
                end else if (long_w) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                clr_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            db_q        <= 1'b0;
            deb_q       <= '0;
            hold_q      <= '0;
            state_q     <= ST_IDLE;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            press_evt_q <= 1'b0;
            long_evt_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.press};
            db_q        <= db_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            state_q     <= state_d;
            // Enable follows the next state so it changes on the same edge as state.
            count_en_q  <= (state_d == ST_RUN);
            count_clr_q <= clr_d;
            press_evt_q <= short_w;
            long_evt_q  <= long_w;
        end
    end

    assign bus.count_en  = count_en_q;
    assign bus.count_clr = count_clr_q;
    assign bus.state     = state_q;
    assign bus.press_evt = press_evt_q;
    assign bus.long_evt  = long_evt_q;

endmodule

// File: tb/tb_press_seq_ctrl.sv
// Directed bench for press_seq_ctrl with DEBOUNCE_CYC=4, LONG_CYC=16, SYNC_STAGES=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Ports: clk and rst generated here; the interface instance carries the rest.
module tb_press_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_press = 0, n_long = 0, n_clr = 0, n_overlap = 0;

    press_seq_ctrl_if bus ();

    press_seq_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYC(4), .LONG_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.press_evt) n_press++;
        if (bus.long_evt)  n_long++;
        if (bus.count_clr) n_clr++;
        if (bus.count_en && bus.count_clr) n_overlap++;
    endtask

    task automatic clr_counts();
        n_press = 0; n_long = 0; n_clr = 0;
    endtask

    task automatic hold_press(input int n);
        bus.press = 1'b1;
        repeat (n) tick();
        bus.press = 1'b0;
    endtask

    // Steps until press_evt is seen; cyc = -1 if the budget expires.
    task automatic wait_evt(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.press_evt) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (bus.state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        n_cmp++; if (bus.count_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %0b want 0", bus.count_en); end
        n_cmp++; if (bus.count_clr !== 1'b0) begin n_err++; $display("FAIL reset_clr: got %0b want 0", bus.count_clr); end
        n_cmp++; if ({bus.press_evt, bus.long_evt} !== 2'b00) begin n_err++; $display("FAIL reset_evts: got %0b want 00", {bus.press_evt, bus.long_evt}); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_clean_press();
        int cyc;
        clr_counts();
        hold_press(6);
        repeat (5) tick();
        n_cmp++; if (bus.press_evt !== 1'b0) begin n_err++; $display("FAIL clean_early_evt: got %0b want 0", bus.press_evt); end
        wait_evt(20, cyc);
        n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL clean_latency: got %0d want 1 more cycle (6 after release)", cyc); end
        n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL clean_state: got %0d want 1", bus.state); end
        n_cmp++; if (bus.count_en !== 1'b1) begin n_err++; $display("FAIL clean_en: got %0b want 1", bus.count_en); end
        repeat (12) tick();
        n_cmp++; if (n_press !== 1) begin n_err++; $display("FAIL clean_npress: got %0d want 1", n_press); end
        n_cmp++; if (n_long !== 0 || n_clr !== 0) begin n_err++; $display("FAIL clean_nlong_nclr: got %0d/%0d want 0/0", n_long, n_clr); end
    endtask

    task automatic test_long_press();
        int long_at = -1;
        logic [1:0] st_at = 2'b11;
        logic en_at = 1'b1, clr_at = 1'b0, clr_after = 1'b1;
        clr_counts();
        bus.press = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.long_evt && long_at < 0) begin
                long_at = i; st_at = bus.state; en_at = bus.count_en; clr_at = bus.count_clr;
            end
            if (long_at > 0 && i == long_at + 1) clr_after = bus.count_clr;
        end
        bus.press = 1'b0;
        repeat (12) tick();
        // db rises 6 cycles after press, hold reaches 16 another 16 cycles later.
        n_cmp++; if (long_at !== 22) begin n_err++; $display("FAIL long_cycle: got %0d want 22", long_at); end
        n_cmp++; if (st_at !== 2'b00) begin n_err++; $display("FAIL long_state: got %0d want 0", st_at); end
        n_cmp++; if (en_at !== 1'b0 || clr_at !== 1'b1) begin n_err++; $display("FAIL long_en_clr: got en=%0b clr=%0b want en=0 clr=1", en_at, clr_at); end
        n_cmp++; if (clr_after !== 1'b0) begin n_err++; $display("FAIL long_clr_width: got %0b want 0", clr_after); end
        n_cmp++; if (n_long !== 1 || n_clr !== 1 || n_press !== 0) begin n_err++; $display("FAIL long_counts: got long=%0d clr=%0d press=%0d want 1/1/0", n_long, n_clr, n_press); end
    endtask

    task automatic test_three_short();
        logic [1:0] exp_st [3] = '{2'b01, 2'b10, 2'b01};
        logic       exp_en [3] = '{1'b1, 1'b0, 1'b1};
        int cyc;
        clr_counts();
        for (int i = 0; i < 3; i++) begin
            hold_press(6);
            wait_evt(20, cyc);
            n_cmp++; if (cyc < 0) begin n_err++; $display("FAIL short%0d_evt: got none within 20 want one", i); end
            n_cmp++; if (bus.state !== exp_st[i] || bus.count_en !== exp_en[i]) begin
                n_err++; $display("FAIL short%0d_state: got st=%0d en=%0b want st=%0d en=%0b", i, bus.state, bus.count_en, exp_st[i], exp_en[i]);
            end
            repeat (4) tick();
        end
        n_cmp++; if (n_press !== 3 || n_clr !== 0) begin n_err++; $display("FAIL short_counts: got press=%0d clr=%0d want 3/0", n_press, n_clr); end
    endtask

    task automatic test_glitch_bounce();
        clr_counts();
        for (int w = 1; w <= 3; w++) begin
            hold_press(w);
            repeat (5) tick();
        end
        n_cmp++; if (n_press !== 0 || bus.state !== 2'b01) begin n_err++; $display("FAIL glitch_ignored: got press=%0d st=%0d want 0/1", n_press, bus.state); end
        for (int i = 0; i < 10; i++) begin
            bus.press = (i % 2 == 0);
            tick();
        end
        hold_press(8);
        repeat (15) tick();
        n_cmp++; if (n_press !== 1 || n_long !== 0) begin n_err++; $display("FAIL bounce_count: got press=%0d long=%0d want 1/0", n_press, n_long); end
        n_cmp++; if (bus.state !== 2'b10 || bus.count_en !== 1'b0) begin n_err++; $display("FAIL bounce_state: got st=%0d en=%0b want 2/0", bus.state, bus.count_en); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        hold_press(6);
        wait_evt(20, cyc);
        n_cmp++; if (bus.state !== 2'b01) begin n_err++; $display("FAIL rstrun_pre_state: got %0d want 1", bus.state); end
        clr_counts();
        bus.press = 1'b1;
        repeat (10) tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.count_en !== 1'b0 || bus.state !== 2'b00) begin n_err++; $display("FAIL rstrun_async: got en=%0b st=%0d want 0/0", bus.count_en, bus.state); end
        n_cmp++; if ({bus.count_clr, bus.press_evt, bus.long_evt} !== 3'b000) begin n_err++; $display("FAIL rstrun_pulses: got %0b want 000", {bus.count_clr, bus.press_evt, bus.long_evt}); end
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        bus.press = 1'b0;
        wait_evt(20, cyc);
        n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL rstrun_release_evt: got %0d want 6", cyc); end
        n_cmp++; if (bus.state !== 2'b01 || bus.count_en !== 1'b1) begin n_err++; $display("FAIL rstrun_post_state: got st=%0d en=%0b want 1/1", bus.state, bus.count_en); end
        repeat (10) tick();
        n_cmp++; if (n_press !== 1 || n_clr !== 0) begin n_err++; $display("FAIL rstrun_counts: got press=%0d clr=%0d want 1/0", n_press, n_clr); end
    endtask

    task automatic test_illegal_state();
        force dut.state_q = 2'b11;
        tick();
        n_cmp++; if (bus.count_en !== 1'b0 || bus.count_clr !== 1'b0) begin n_err++; $display("FAIL illegal_en_clr: got en=%0b clr=%0b want 0/0", bus.count_en, bus.count_clr); end
        release dut.state_q;
        tick();
        n_cmp++; if (bus.state !== 2'b00 || bus.count_en !== 1'b0) begin n_err++; $display("FAIL illegal_recover: got st=%0d en=%0b want 0/0", bus.state, bus.count_en); end
    endtask

    initial begin
        bus.press = 1'b0;
        test_reset();
        test_clean_press();
        test_long_press();
        test_three_short();
        test_glitch_bounce();
        test_reset_mid_run();
        test_illegal_state();
        n_cmp++; if (n_overlap !== 0) begin n_err++; $display("FAIL en_clr_overlap: got %0d cycles want 0", n_overlap); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
